// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Width of a counter that must hold values 0 .. cycles_per_bit-1.
    function automatic int cnt_width(input int cycles_per_bit);
        return (cycles_per_bit > 2) ? $clog2(cycles_per_bit) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input; resets to 1 (idle line).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values of the two synchroniser stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages, both released at logic 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with a single-entry valid/ready byte output.
// Optional build macro UART_RX_FRAMING_CHECK_EN: drop frames whose stop bit samples low.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       tready,
    output logic       tvalid,
    output logic [7:0] tdata,
    output logic       overflow
);

    localparam int CW = cnt_width(cycles_per_bit);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(cycles_per_bit / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(cycles_per_bit - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tvalid_q, tvalid_d;
    logic [7:0]     tdata_q, tdata_d;
    logic           overflow_q, overflow_d;
    logic           frame_done;

    sync_2ff u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Receive FSM, bit timing and output-slot update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q && !tready;
        overflow_d = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
                    frame_done = rx_s;
`else
                    frame_done = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A slot being accepted this cycle counts as free for the new byte.
        if (frame_done) begin
            if (!tvalid_q || tready) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any frame and empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            overflow_q <= overflow_d;
        end
    end

    assign tvalid   = tvalid_q;
    assign tdata    = tdata_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: vector table, hand-written corner cases,
// random frames against a cycle-level model of the single-entry output slot.
module tb_uart_rx_axis;

    localparam int C = 434;
    localparam int H = C / 2;
`ifdef UART_RX_FRAMING_CHECK_EN
    localparam bit FRAMING = 1'b1;
`else
    localparam bit FRAMING = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tready = 1'b0;
    logic       tvalid;
    logic [7:0] tdata;
    logic       overflow;

    always #10 clk = ~clk;

    uart_rx_axis #(.cycles_per_bit(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .tready   (tready),
        .tvalid   (tvalid),
        .tdata    (tdata),
        .overflow (overflow)
    );

    typedef struct {
        int         cmp_cyc;
        logic [7:0] data;
        bit         stop;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         exp_valid;
        logic [7:0] exp_tdata;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    frame_t     pend_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovf = 1'b0;
    bit         model_ok = 1'b1;
    int         ovf_cnt = 0;
    int         xfer_cnt = 0;
    logic [7:0] last_xfer = 8'h00;
    int         rdy_mode = 0;
    int         rdy_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Serialises one 8N1 frame and records the edge on which the stop bit gets sampled.
    task automatic send_frame(input logic [7:0] data, input bit stop, input int gap);
        frame_t f;
        f.cmp_cyc = cyc + 3 + H + 9 * C;
        f.data    = data;
        f.stop    = stop;
        pend_q.push_back(f);
        rdy_cyc = f.cmp_cyc;
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (C) tick();
        end
        rx = stop;
        repeat (C) tick();
        rx = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic drain();
        rdy_mode = 1;
        repeat (3) tick();
        rdy_mode = 0;
        tick();
    endtask

    // Reference slot model, per-cycle comparison, ready driver and transfer monitor.
    always @(posedge clk) begin : mdl
        frame_t f;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
            pend_q.delete();
        end else begin
            if (m_valid && tready) m_valid = 1'b0;
            m_ovf = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].cmp_cyc == cyc) begin
                f = pend_q.pop_front();
                if (f.stop || !FRAMING) begin
                    if (!m_valid) begin
                        m_valid = 1'b1;
                        m_data  = f.data;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        #1;
        if (rst_n) begin
            if (overflow === 1'b1) ovf_cnt++;
            if (model_ok) begin
                checks++;
                if ({tvalid, overflow} !== {m_valid, m_ovf} || (m_valid && tdata !== m_data)) begin
                    failures++;
                    model_ok = 1'b0;
                    $display("FAIL cycle_model at cycle %0d: got tvalid=%b tdata=%h overflow=%b, expected tvalid=%b tdata=%h overflow=%b",
                             cyc, tvalid, tdata, overflow, m_valid, m_data, m_ovf);
                end
            end
        end
        #2;
        case (rdy_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = (cyc + 1 == rdy_cyc);
        endcase
        if (rst_n && tvalid && tready) begin
            xfer_cnt++;
            last_xfer = tdata;
        end
    end

    vec_t vecs[4];

    initial begin
        int ovf0;
        int x0;
        vecs[0] = '{8'h4D, 1'b1, 1'b1, 8'h4D};
        vecs[1] = '{8'hA5, 1'b0, !FRAMING, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF};

        // Reset with the line held low.
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (3) tick();
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tdata", tdata, 0);
        chk("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("tvalid_low_after_release", tvalid, 0);
        end
        rx = 1'b1;
        repeat (C) tick();

        // Vector table: one frame each, then a single-cycle accept.
        for (int v = 0; v < 4; v++) begin
            ovf0 = ovf_cnt;
            x0   = xfer_cnt;
            rdy_mode = 0;
            send_frame(vecs[v].data, vecs[v].stop, 20);
            chk($sformatf("vec%0d_tvalid", v), tvalid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) chk($sformatf("vec%0d_tdata", v), tdata, vecs[v].exp_tdata);
            rdy_mode = 1;
            tick();
            rdy_mode = 0;
            chk($sformatf("vec%0d_tvalid_after_accept", v), tvalid, 0);
            chk($sformatf("vec%0d_xfers", v), xfer_cnt - x0, vecs[v].exp_valid);
            if (vecs[v].exp_valid) chk($sformatf("vec%0d_xfer_data", v), last_xfer, vecs[v].exp_tdata);
            chk($sformatf("vec%0d_overflow_count", v), ovf_cnt - ovf0, 0);
            tick();
        end

        // Overflow: second byte arrives while the first is still held.
        ovf0 = ovf_cnt;
        rdy_mode = 0;
        send_frame(8'd77, 1'b1, 0);
        chk("ovf_first_tvalid", tvalid, 1);
        send_frame(8'd77, 1'b1, 0);
        chk("ovf_count", ovf_cnt - ovf0, 1);
        chk("ovf_tvalid_held", tvalid, 1);
        chk("ovf_tdata_held", tdata, 77);

        // Reset mid-frame with a byte pending.
        rx = 1'b0;
        repeat (3 * C) tick();
        rst_n = 1'b0;
        tick();
        chk("midreset_tvalid_cleared", tvalid, 0);
        tick();
        rx    = 1'b1;
        rst_n = 1'b1;
        ovf0  = ovf_cnt;
        repeat (8 * C) tick();
        chk("midreset_no_tvalid", tvalid, 0);
        chk("midreset_no_overflow", ovf_cnt - ovf0, 0);

        // Short low glitch, then a good frame proves the FSM returned to idle.
        rx = 1'b0;
        repeat (H / 2) tick();
        rx = 1'b1;
        repeat (2 * C) tick();
        chk("glitch_no_tvalid", tvalid, 0);
        send_frame(8'h3C, 1'b1, 0);
        chk("after_glitch_tvalid", tvalid, 1);
        chk("after_glitch_tdata", tdata, 8'h3C);
        drain();

        // Accept on the exact stop-sample edge of the next byte.
        ovf0 = ovf_cnt;
        rdy_mode = 0;
        send_frame(8'h11, 1'b1, 0);
        chk("hold11_tdata", tdata, 8'h11);
        x0 = xfer_cnt;
        rdy_mode = 3;
        send_frame(8'h22, 1'b1, 0);
        rdy_mode = 0;
        chk("same_edge_xfers", xfer_cnt - x0, 1);
        chk("same_edge_xfer_data", last_xfer, 8'h11);
        chk("same_edge_tvalid", tvalid, 1);
        chk("same_edge_tdata", tdata, 8'h22);
        chk("same_edge_no_overflow", ovf_cnt - ovf0, 0);
        drain();

        // Random frames with random ready behaviour, checked by the cycle model.
        for (int r = 0; r < 4; r++) begin
            rdy_mode = int'($urandom_range(0, 2));
            send_frame(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 40)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
